ram_block_copier: RTL and testbench

RAM_BLOCK_COPIER -- requirements
Module: ram_block_copier

---
 rtl/ram_block_copier.sv | 123 ++++++++++++
 tb/tb_ram_block_copier.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_copier.sv
// Block copier between two regions of a single-port-per-direction RAM with memmove semantics.
// One word is read and the previously read word is written in every COPY cycle.
module ram_block_copier #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W:0]   Length,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W-1:0] ramReadAddress,
  output logic              ramReadEn,
  input  logic [DATA_W-1:0] ramReadData,
  output logic [ADDR_W-1:0] ramWriteAddress,
  output logic [DATA_W-1:0] ramWriteData,
  output logic              ramWriteEn
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ADDR_W + 2;
  localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] srcQ, dstQ;
  logic [CNT_W-1:0]  lenQ, idxQ;
  logic [DATA_W-1:0] holdQ;
  logic              descQ, errQ;

  logic [SUM_W-1:0]  srcSum, dstSum;
  logic              reject, trivial, readPhase, writePhase, active;
  logic [CNT_W-1:0]  readOffset, writeOffset;

  // Request screening, done on the live inputs in the Start cycle.
  assign srcSum  = SUM_W'(SrcAddr) + SUM_W'(Length);
  assign dstSum  = SUM_W'(DstAddr) + SUM_W'(Length);
  assign reject  = (SUM_W'(Length) > DEPTH) || (srcSum > DEPTH) || (dstSum > DEPTH);
  assign trivial = (Length == '0) || (SrcAddr == DstAddr);

  assign readPhase  = idxQ < lenQ;
  assign writePhase = idxQ != '0;
  assign active     = !Reset && !Abort;

  // Descending order walks from the top of the block so an overlapping higher destination is safe.
  assign readOffset  = descQ ? (lenQ - CNT_W'(1) - idxQ) : idxQ;
  assign writeOffset = descQ ? (lenQ - idxQ) : (idxQ - CNT_W'(1));

  assign Busy  = !Reset && (state != IDLE);
  assign Done  = !Reset && (state == DONE);
  assign Error = Done && errQ;

  always_comb begin
    stateNext       = state;
    ramReadEn       = 1'b0;
    ramReadAddress  = '0;
    ramWriteEn      = 1'b0;
    ramWriteAddress = '0;
    ramWriteData    = '0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (reject || trivial) stateNext = DONE;
          else                   stateNext = COPY;
        end
      end
      COPY: begin
        ramReadAddress  = ADDR_W'(CNT_W'(srcQ) + readOffset);
        ramWriteAddress = ADDR_W'(CNT_W'(dstQ) + writeOffset);
        ramWriteData    = holdQ;
        ramReadEn       = active && readPhase;
        ramWriteEn      = active && writePhase;
        if (Abort)             stateNext = IDLE;
        else if (idxQ == lenQ) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      srcQ  <= '0;
      dstQ  <= '0;
      lenQ  <= '0;
      idxQ  <= '0;
      holdQ <= '0;
      descQ <= 1'b0;
      errQ  <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (Start) begin
            srcQ  <= SrcAddr;
            dstQ  <= DstAddr;
            lenQ  <= Length;
            idxQ  <= '0;
            descQ <= DstAddr > SrcAddr;
            errQ  <= reject;
          end
        end
        COPY: begin
          if (Abort) begin
            idxQ <= '0;
          end else begin
            if (readPhase) holdQ <= ramReadData;
            idxQ <= idxQ + CNT_W'(1);
          end
        end
        default: idxQ <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier with a behavioural 64x8 RAM model.
// Each task drives one scenario and checks hand-computed results inline.
module tb_ram_block_copier;

  logic       Clk = 1'b0;
  logic       Reset, Start, Abort;
  logic [5:0] SrcAddr, DstAddr;
  logic [6:0] Length;
  logic       Busy, Done, Error;
  logic [5:0] ramReadAddress, ramWriteAddress;
  logic       ramReadEn, ramWriteEn;
  logic [7:0] ramReadData, ramWriteData;

  logic [7:0] mem [64];
  logic       preload = 1'b0;
  int         writeCount = 0;
  int         collisions = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 Clk = ~Clk;

  ram_block_copier #(.ADDR_W(6), .DATA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Length(Length), .Abort(Abort), .Busy(Busy), .Done(Done), .Error(Error),
    .ramReadAddress(ramReadAddress), .ramReadEn(ramReadEn), .ramReadData(ramReadData),
    .ramWriteAddress(ramWriteAddress), .ramWriteData(ramWriteData), .ramWriteEn(ramWriteEn)
  );

  assign ramReadData = mem[ramReadAddress];

  // RAM write port plus traffic monitor.
  always @(posedge Clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) mem[k] <= 8'(k);
    end else if (ramWriteEn) begin
      mem[ramWriteAddress] <= ramWriteData;
    end
    if (ramWriteEn) writeCount <= writeCount + 1;
    if (ramWriteEn && ramReadEn && (ramWriteAddress == ramReadAddress)) collisions <= collisions + 1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    step();
    preload = 1'b0;
  endtask

  task automatic start_req(input logic [5:0] src, input logic [5:0] dst, input logic [6:0] len);
    SrcAddr = src;
    DstAddr = dst;
    Length  = len;
    Start   = 1'b1;
    step();
    Start   = 1'b0;
  endtask

  // Returns the cycle (Start cycle = 0) in which Done is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!Done && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Abort = 1'b1;
    SrcAddr = 6'd0; DstAddr = 6'd5; Length = 7'd3;
    step();
    step();
    checks++;
    if ({Busy, Done, Error, ramReadEn, ramWriteEn} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {Busy, Done, Error, ramReadEn, ramWriteEn});
    end
    checks++;
    if ({ramReadAddress, ramWriteAddress, ramWriteData} !== 20'd0) begin
      failures++;
      $display("FAIL reset_bus: got %h expected 0", {ramReadAddress, ramWriteAddress, ramWriteData});
    end
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
    step();
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b expected 0", Busy);
    end
  endtask

  task automatic test_descending();
    int lat, w0;
    do_preload();
    w0 = writeCount;
    start_req(6'd0, 6'd32, 7'd4);
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL desc_busy: got %b expected 1", Busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL desc_latency: got %0d expected 6", lat);
    end
    checks++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL desc_done_flags: got err=%b busy=%b expected err=0 busy=1", Error, Busy);
    end
    step();
    checks++;
    if ({mem[32], mem[33], mem[34], mem[35]} !== {8'd0, 8'd1, 8'd2, 8'd3}) begin
      failures++;
      $display("FAIL desc_data: got %h expected 00010203", {mem[32], mem[33], mem[34], mem[35]});
    end
    checks++;
    if (mem[31] !== 8'd31 || mem[36] !== 8'd36 || writeCount - w0 !== 4) begin
      failures++;
      $display("FAIL desc_extent: got m31=%0d m36=%0d writes=%0d expected 31 36 4",
               mem[31], mem[36], writeCount - w0);
    end
  endtask

  task automatic test_overlap();
    int lat, c0;
    c0 = collisions;
    do_preload();
    start_req(6'd10, 6'd8, 7'd5);
    wait_done(lat);
    step();
    checks++;
    if ({mem[8], mem[9], mem[10], mem[11], mem[12], mem[13]} !==
        {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd13}) begin
      failures++;
      $display("FAIL overlap_asc: got %h expected 0a0b0c0d0e0d",
               {mem[8], mem[9], mem[10], mem[11], mem[12], mem[13]});
    end
    do_preload();
    start_req(6'd8, 6'd10, 7'd5);
    wait_done(lat);
    step();
    checks++;
    if ({mem[9], mem[10], mem[11], mem[12], mem[13], mem[14], mem[15]} !==
        {8'd9, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd15}) begin
      failures++;
      $display("FAIL overlap_desc: got %h expected 0908090a0b0c0f",
               {mem[9], mem[10], mem[11], mem[12], mem[13], mem[14], mem[15]});
    end
    checks++;
    if (collisions - c0 !== 0) begin
      failures++;
      $display("FAIL overlap_addr_clash: got %0d expected 0", collisions - c0);
    end
  endtask

  task automatic test_reject_and_trivial();
    int lat, w0;
    w0 = writeCount;
    start_req(6'd60, 6'd0, 7'd8);
    wait_done(lat);
    checks++;
    if (lat !== 1 || Error !== 1'b1) begin
      failures++;
      $display("FAIL reject: got lat=%0d err=%b expected lat=1 err=1", lat, Error);
    end
    step();
    start_req(6'd0, 6'd0, 7'd64);
    wait_done(lat);
    checks++;
    if (lat !== 1 || Error !== 1'b0) begin
      failures++;
      $display("FAIL same_addr: got lat=%0d err=%b expected lat=1 err=0", lat, Error);
    end
    step();
    start_req(6'd3, 6'd9, 7'd0);
    wait_done(lat);
    checks++;
    if (lat !== 1 || Error !== 1'b0) begin
      failures++;
      $display("FAIL zero_len: got lat=%0d err=%b expected lat=1 err=0", lat, Error);
    end
    step();
    start_req(6'd0, 6'd1, 7'd64);
    wait_done(lat);
    checks++;
    if (lat !== 1 || Error !== 1'b1) begin
      failures++;
      $display("FAIL dst_overrun: got lat=%0d err=%b expected lat=1 err=1", lat, Error);
    end
    step();
    checks++;
    if (writeCount - w0 !== 0) begin
      failures++;
      $display("FAIL reject_traffic: got %0d writes expected 0", writeCount - w0);
    end
  endtask

  task automatic test_abort();
    int w0, dones;
    do_preload();
    w0 = writeCount;
    start_req(6'd0, 6'd20, 7'd10);
    repeat (4) step();
    Abort = 1'b1;
    #1;
    checks++;
    if (ramWriteEn !== 1'b0 || ramReadEn !== 1'b0) begin
      failures++;
      $display("FAIL abort_gate: got we=%b re=%b expected 0 0", ramWriteEn, ramReadEn);
    end
    step();
    Abort = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %b expected 0", Busy);
    end
    dones = 0;
    repeat (15) begin
      if (Done) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL abort_done: got %0d expected 0", dones);
    end
    checks++;
    if ({mem[26], mem[27], mem[28], mem[29], mem[30]} !== {8'd26, 8'd7, 8'd8, 8'd9, 8'd30} ||
        writeCount - w0 !== 3) begin
      failures++;
      $display("FAIL abort_data: got %h writes=%0d expected 1a0708091e writes=3",
               {mem[26], mem[27], mem[28], mem[29], mem[30]}, writeCount - w0);
    end
  endtask

  task automatic test_reset_mid_copy();
    int w0, dones;
    do_preload();
    w0 = writeCount;
    start_req(6'd0, 6'd20, 7'd10);
    repeat (2) step();
    Reset = 1'b1;
    #1;
    checks++;
    if ({Busy, ramWriteEn, ramReadEn} !== 3'b0) begin
      failures++;
      $display("FAIL reset_mid_gate: got %b expected 000", {Busy, ramWriteEn, ramReadEn});
    end
    step();
    Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Error, ramReadEn, ramWriteEn} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: got %b expected 00000", {Busy, Done, Error, ramReadEn, ramWriteEn});
    end
    dones = 0;
    repeat (15) begin
      if (Done) dones++;
      step();
    end
    checks++;
    if (dones !== 0 || writeCount - w0 !== 1 || mem[29] !== 8'd9 || mem[28] !== 8'd28) begin
      failures++;
      $display("FAIL reset_mid_writes: got dones=%0d writes=%0d m29=%0d m28=%0d expected 0 1 9 28",
               dones, writeCount - w0, mem[29], mem[28]);
    end
  endtask

  task automatic test_start_during_copy();
    int dones, w0;
    do_preload();
    w0 = writeCount;
    start_req(6'd0, 6'd40, 7'd3);
    start_req(6'd50, 6'd2, 7'd5);
    dones = 0;
    repeat (20) begin
      if (Done) dones++;
      step();
    end
    checks++;
    if (dones !== 1 || writeCount - w0 !== 3) begin
      failures++;
      $display("FAIL start_ignored: got dones=%0d writes=%0d expected 1 3", dones, writeCount - w0);
    end
    checks++;
    if ({mem[2], mem[40], mem[41], mem[42]} !== {8'd2, 8'd0, 8'd1, 8'd2}) begin
      failures++;
      $display("FAIL start_ignored_data: got %h expected 02000102", {mem[2], mem[40], mem[41], mem[42]});
    end
  endtask

  task automatic test_back_to_back();
    int doneCycles[$];
    SrcAddr = 6'd60; DstAddr = 6'd0; Length = 7'd8;
    Start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (Done) doneCycles.push_back(c);
    end
    Start = 1'b0;
    step();
    step();
    checks++;
    if (doneCycles.size() !== 3 || doneCycles[0] !== 1 || doneCycles[1] !== 3 || doneCycles[2] !== 5) begin
      failures++;
      $display("FAIL back_to_back: got %0d dones first at %0d expected 3 dones at 1,3,5",
               doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0;
    test_reset();
    test_descending();
    test_overlap();
    test_reject_and_trivial();
    test_abort();
    test_reset_mid_copy();
    test_start_during_copy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
